// File: rtl/elevator_scheduler.sv
// SCAN elevator car scheduler: latches floor calls, sequences travel and door
// timing from a tick enable, and registers position, target and state outputs.
module elevator_scheduler_chk #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input logic                  clk,
  input logic                  nrst,
  input logic [FLOOR_W-1:0]    floor,
  input logic [1:0]            state,
  input logic [NUM_FLOORS-1:0] dest
);

  // Car stays inside the shaft, never moves past an end floor, target is one-hot
  always @(posedge clk) begin
    if (nrst) begin
      assert ({1'b0, floor} < (FLOOR_W+1)'(NUM_FLOORS))
        else $error("current_floor out of range");
      assert (!(state == 2'b01 && floor == FLOOR_W'(NUM_FLOORS-1)))
        else $error("moving up from top floor");
      assert (!(state == 2'b10 && floor == FLOOR_W'(0)))
        else $error("moving down from bottom floor");
      assert ($onehot(dest))
        else $error("destination not one-hot");
    end
  end

endmodule

module elevator_scheduler #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  tick,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] destination,
  output logic [1:0]            sim_state,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_DOWN = 2'b10;
  localparam logic [1:0] ST_DOOR = 2'b11;

  localparam int TMR_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0]   TRAVEL_LAST = TMR_W'(TRAVEL_TICKS - 1);
  localparam logic [TMR_W-1:0]   DOOR_LAST   = TMR_W'(DOOR_TICKS - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE   = FLOOR_W'(1);

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] oh;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      oh[i] = (FLOOR_W'(i) == f);
    end
    return oh;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] mask_above(input logic [NUM_FLOORS-1:0] p,
                                                       input logic [FLOOR_W-1:0]    f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = p[i] & (FLOOR_W'(i) > f);
    end
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] mask_below(input logic [NUM_FLOORS-1:0] p,
                                                       input logic [FLOOR_W-1:0]    f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      m[i] = p[i] & (FLOOR_W'(i) < f);
    end
    return m;
  endfunction

  // Nearest call ahead wins; lowest bit above and highest bit below are the nearest ones
  function automatic logic [NUM_FLOORS-1:0] pick_dest(input logic [NUM_FLOORS-1:0] p,
                                                      input logic [FLOOR_W-1:0]    f,
                                                      input logic                  up);
    logic [NUM_FLOORS-1:0] m_up, m_dn, rev, rev_lo, near_up, near_dn, res;
    m_up    = mask_above(p, f);
    m_dn    = mask_below(p, f);
    near_up = m_up & (~m_up + NUM_FLOORS'(1));
    for (int i = 0; i < NUM_FLOORS; i++) begin
      rev[i] = m_dn[NUM_FLOORS-1-i];
    end
    rev_lo = rev & (~rev + NUM_FLOORS'(1));
    for (int i = 0; i < NUM_FLOORS; i++) begin
      near_dn[i] = rev_lo[NUM_FLOORS-1-i];
    end
    res = up ? ((|m_up) ? near_up : near_dn) : ((|m_dn) ? near_dn : near_up);
    return (|res) ? res : floor_onehot(f);
  endfunction

  logic [1:0]            r_state;
  logic [FLOOR_W-1:0]    r_floor;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_dir_up;
  logic [TMR_W-1:0]      r_timer;
  logic [NUM_FLOORS-1:0] r_dest;

  logic [1:0]            w_state_nxt;
  logic [FLOOR_W-1:0]    w_floor_nxt;
  logic [NUM_FLOORS-1:0] w_pending_nxt;
  logic                  w_dir_nxt;
  logic [TMR_W-1:0]      w_timer_nxt;
  logic [NUM_FLOORS-1:0] w_dest_nxt;
  logic [NUM_FLOORS-1:0] w_here_oh;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [FLOOR_W-1:0]    w_floor_step;
  logic                  w_above;
  logic                  w_below;
  logic [1:0]            w_pick_state;
  logic                  w_pick_dir;

  assign w_here_oh    = floor_onehot(r_floor);
  assign w_above      = |mask_above(r_pending, r_floor);
  assign w_below      = |mask_below(r_pending, r_floor);
  assign w_floor_step = (r_state == ST_UP) ? (r_floor + FLOOR_ONE) : (r_floor - FLOOR_ONE);
  // A press at the open-door floor only holds the door, it never becomes a call
  assign w_set        = (r_state == ST_DOOR) ? (call_req & ~w_here_oh) : call_req;

  // SCAN choice: keep heading while work lies ahead, otherwise turn, otherwise rest
  always_comb begin
    w_pick_state = ST_IDLE;
    w_pick_dir   = r_dir_up;
    if (r_dir_up && w_above) begin
      w_pick_state = ST_UP;
      w_pick_dir   = 1'b1;
    end else if (!r_dir_up && w_below) begin
      w_pick_state = ST_DOWN;
      w_pick_dir   = 1'b0;
    end else if (w_above) begin
      w_pick_state = ST_UP;
      w_pick_dir   = 1'b1;
    end else if (w_below) begin
      w_pick_state = ST_DOWN;
      w_pick_dir   = 1'b0;
    end else begin
      w_pick_state = ST_IDLE;
      w_pick_dir   = r_dir_up;
    end
  end

  // Next-state, position, timer and call-clear decisions
  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir_up;
    w_timer_nxt = r_timer;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (r_pending[r_floor]) begin
          w_state_nxt = ST_DOOR;
          w_clr       = w_here_oh;
        end else begin
          w_state_nxt = w_pick_state;
          w_dir_nxt   = w_pick_dir;
        end
      end
      ST_UP, ST_DOWN: begin
        if (tick && r_timer == TRAVEL_LAST) begin
          w_timer_nxt = '0;
          w_floor_nxt = w_floor_step;
          if (r_pending[w_floor_step]) begin
            w_state_nxt = ST_DOOR;
            w_clr       = floor_onehot(w_floor_step);
          end else begin
            w_state_nxt = r_state;
          end
        end else if (tick) begin
          w_timer_nxt = r_timer + TMR_ONE;
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      ST_DOOR: begin
        if (call_req[r_floor]) begin
          w_timer_nxt = '0;
        end else if (tick && r_timer == DOOR_LAST) begin
          w_state_nxt = w_pick_state;
          w_dir_nxt   = w_pick_dir;
          w_timer_nxt = '0;
        end else if (tick) begin
          w_timer_nxt = r_timer + TMR_ONE;
        end else begin
          w_timer_nxt = r_timer;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_timer_nxt = '0;
      end
    endcase
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
  end

  assign w_dest_nxt = pick_dest(w_pending_nxt, w_floor_nxt, w_dir_nxt);

  // Car state registers; reset parks the car at floor 0 with no calls
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_floor   <= '0;
      r_pending <= '0;
      r_dir_up  <= 1'b1;
      r_timer   <= '0;
      r_dest    <= NUM_FLOORS'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_floor   <= w_floor_nxt;
      r_pending <= w_pending_nxt;
      r_dir_up  <= w_dir_nxt;
      r_timer   <= w_timer_nxt;
      r_dest    <= w_dest_nxt;
    end
  end

  assign current_floor = r_floor;
  assign destination   = r_dest;
  assign sim_state     = r_state;
  assign pending       = r_pending;
  assign dir_up        = r_dir_up;

  elevator_scheduler_chk #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_chk (
    .clk   (clk),
    .nrst  (nrst),
    .floor (r_floor),
    .state (r_state),
    .dest  (r_dest)
  );

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus randomized traffic
// checked against a floor-by-floor behavioural model of the SCAN car.
module tb_elevator_scheduler;

  localparam int NF = 8;
  localparam int TT = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        tick;
  logic [7:0]  call_req;
  logic [2:0]  current_floor;
  logic [7:0]  destination;
  logic [1:0]  sim_state;
  logic [7:0]  pending;
  logic        dir_up;
  logic [21:0] dut_vec;

  int errors = 0;
  int checks = 0;

  // model: 0 idle, 1 up, 2 down, 3 door
  int       m_floor, m_state, m_timer;
  bit [7:0] m_pend, m_dest;
  bit       m_dir;

  elevator_scheduler #(.NUM_FLOORS(NF), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .tick          (tick),
    .call_req      (call_req),
    .current_floor (current_floor),
    .destination   (destination),
    .sim_state     (sim_state),
    .pending       (pending),
    .dir_up        (dir_up)
  );

  always #5 clk = ~clk;

  assign dut_vec = {current_floor, destination, sim_state, pending, dir_up};

  function automatic logic [21:0] exp_vec();
    return {3'(m_floor), m_dest, 2'(m_state), m_pend, m_dir};
  endfunction

  function automatic int scan_next(bit dir, bit ab, bit be);
    if (dir && ab) return 1;
    if (!dir && be) return 2;
    if (ab) return 1;
    if (be) return 2;
    return 0;
  endfunction

  // Walk outward floor by floor: first the travel direction, then the other way
  function automatic bit [7:0] model_dest(bit [7:0] p, int f, bit up);
    bit [7:0] r;
    bit       hit, dir;
    int       t;
    r = 8'h00;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dir = (k == 0) ? up : !up;
      for (int d = 1; d < NF; d++) begin
        t = dir ? f + d : f - d;
        if (!hit && t >= 0 && t < NF) begin
          if (p[t[2:0]]) begin
            r = 8'h01 << t;
            hit = 1'b1;
          end
        end
      end
    end
    if (!hit) r = 8'h01 << f;
    return r;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_state = 0; m_timer = 0; m_pend = 8'h00; m_dir = 1'b1; m_dest = 8'h01;
  endtask

  task automatic model_step(input bit tk, input logic [7:0] cr);
    bit       ab, be, nd;
    bit [7:0] np;
    int       nf, ns, nt;
    bit [2:0] fl;
    fl = m_floor[2:0];
    ab = 1'b0; be = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_floor) ab = 1'b1;
      if (m_pend[i] && i < m_floor) be = 1'b1;
    end
    np = m_pend; nf = m_floor; ns = m_state; nt = m_timer; nd = m_dir;
    for (int i = 0; i < NF; i++)
      if (cr[i] && !(m_state == 3 && i == m_floor)) np[i] = 1'b1;
    if (m_state == 0) begin
      if (m_pend[fl]) begin ns = 3; np[fl] = 1'b0; end
      else ns = scan_next(m_dir, ab, be);
    end else if (m_state == 3) begin
      if (cr[fl]) nt = 0;
      else if (tk) begin
        if (m_timer == DT - 1) begin ns = scan_next(m_dir, ab, be); nt = 0; end
        else nt = m_timer + 1;
      end
    end else if (tk) begin
      if (m_timer == TT - 1) begin
        nf = (m_state == 1) ? m_floor + 1 : m_floor - 1;
        nt = 0;
        if (m_pend[nf[2:0]]) begin ns = 3; np[nf[2:0]] = 1'b0; end
      end else nt = m_timer + 1;
    end
    if (ns == 1) nd = 1'b1;
    else if (ns == 2) nd = 1'b0;
    m_floor = nf; m_state = ns; m_timer = nt; m_pend = np; m_dir = nd;
    m_dest = model_dest(np, nf, nd);
  endtask

  task automatic do_reset();
    nrst = 1'b0; tick = 1'b0; call_req = 8'h00;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    model_reset();
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1 unit later
  task automatic step(input bit tk, input logic [7:0] cr);
    tick = tk; call_req = cr;
    @(posedge clk);
    model_step(tk, cr);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== {3'd0, 8'h01, 2'b00, 8'h00, 1'b1}) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dut_vec, {3'd0, 8'h01, 2'b00, 8'h00, 1'b1});
    end
  endtask

  task automatic test_single_call();
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h20);
    checks++;
    if (pending !== 8'h20) begin errors++; $display("FAIL single_latch: got %h expected 20", pending); end
    step(1'b1, 8'h00);
    checks++;
    if (sim_state !== 2'b01) begin errors++; $display("FAIL single_start: got %b expected 01", sim_state); end
    for (int e = 3; e <= 21; e++) step(1'b1, 8'h00);
    checks++;
    if ({current_floor, sim_state} !== {3'd4, 2'b01}) begin
      errors++; $display("FAIL single_e21: got floor %0d state %b expected 4 01", current_floor, sim_state);
    end
    step(1'b1, 8'h00);
    checks++;
    if ({current_floor, sim_state, pending} !== {3'd5, 2'b11, 8'h00}) begin
      errors++; $display("FAIL single_arrive: got floor %0d state %b pend %h", current_floor, sim_state, pending);
    end
    repeat (3) step(1'b1, 8'h00);
    checks++;
    if ({sim_state, destination} !== {2'b00, 8'h20}) begin
      errors++; $display("FAIL single_close: got state %b dest %h expected 00 20", sim_state, destination);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL single_model: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_scan_order();
    int         fl_q[$];
    logic [7:0] ds_q[$];
    bit         dr_q[$];
    logic [1:0] prev;
    bit         done, after7_ok;
    done = 1'b0; after7_ok = 1'b0;
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h80);
    repeat (13) step(1'b1, 8'h00);
    checks++;
    if ({current_floor, sim_state} !== {3'd3, 2'b01}) begin
      errors++; $display("FAIL scan_setup: got floor %0d state %b expected 3 01", current_floor, sim_state);
    end
    step(1'b1, 8'h11);
    checks++;
    if ({pending, destination} !== {8'h91, 8'h10}) begin
      errors++; $display("FAIL scan_press: got pend %h dest %h expected 91 10", pending, destination);
    end
    for (int c = 0; c < 300 && !done; c++) begin
      prev = sim_state;
      step(1'b1, 8'h00);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL scan_model: got %h expected %h", dut_vec, exp_vec()); end
      if (sim_state == 2'b11 && prev != 2'b11) begin
        fl_q.push_back(int'(current_floor)); ds_q.push_back(destination); dr_q.push_back(dir_up);
      end
      if (prev == 2'b11 && sim_state != 2'b11 && current_floor == 3'd7)
        after7_ok = (dir_up === 1'b0 && sim_state === 2'b10);
      if (sim_state == 2'b00) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL scan_timeout: got busy expected idle"); end
    checks++;
    if (fl_q.size() != 3) begin
      errors++; $display("FAIL scan_stops: got %0d stops expected 3", fl_q.size());
    end else begin
      checks++;
      if (fl_q[0] != 4 || fl_q[1] != 7 || fl_q[2] != 0) begin
        errors++; $display("FAIL scan_order: got %0d %0d %0d expected 4 7 0", fl_q[0], fl_q[1], fl_q[2]);
      end
      checks++;
      if (ds_q[0] !== 8'h80 || ds_q[1] !== 8'h01 || ds_q[2] !== 8'h01) begin
        errors++; $display("FAIL scan_dest: got %h %h %h expected 80 01 01", ds_q[0], ds_q[1], ds_q[2]);
      end
      checks++;
      if (dr_q[0] !== 1'b1 || dr_q[1] !== 1'b1 || dr_q[2] !== 1'b0) begin
        errors++; $display("FAIL scan_dir: got %b%b%b expected 110", dr_q[0], dr_q[1], dr_q[2]);
      end
    end
    checks++;
    if (!after7_ok) begin errors++; $display("FAIL scan_turn: got no down turn after floor 7 door expected dir 0 state 10"); end
  endtask

  task automatic test_call_at_floor();
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h00);
    checks++;
    if ({sim_state, pending} !== {2'b11, 8'h00}) begin
      errors++; $display("FAIL here_open: got state %b pend %h expected 11 00", sim_state, pending);
    end
    step(1'b1, 8'h00);
    step(1'b1, 8'h01);
    checks++;
    if ({sim_state, pending} !== {2'b11, 8'h00}) begin
      errors++; $display("FAIL here_repress: got state %b pend %h expected 11 00", sim_state, pending);
    end
    repeat (2) step(1'b1, 8'h00);
    checks++;
    if (sim_state !== 2'b11) begin errors++; $display("FAIL here_extend: got %b expected 11", sim_state); end
    step(1'b1, 8'h00);
    checks++;
    if (sim_state !== 2'b00) begin errors++; $display("FAIL here_close: got %b expected 00", sim_state); end
  endtask

  task automatic test_tick_gating();
    int  f1, f2;
    bit  tk;
    f1 = -1; f2 = -1;
    do_reset();
    for (int c = 0; c < 200 && f2 < 0; c++) begin
      tk = (c % 4 == 3);
      step(tk, (c == 1) ? 8'h04 : 8'h00);
      if (current_floor == 3'd1 && f1 < 0) f1 = c;
      if (current_floor == 3'd2 && f2 < 0) f2 = c;
    end
    checks++;
    if (f1 < 0 || f2 - f1 != 16) begin errors++; $display("FAIL tick_period: got %0d clks expected 16", f2 - f1); end
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h80);
    repeat (5) step(1'b1, 8'h00);
    for (int c = 0; c < 20; c++) step(1'b0, (c == 3) ? 8'h40 : 8'h00);
    checks++;
    if ({current_floor, sim_state, pending} !== {3'd1, 2'b01, 8'hC0}) begin
      errors++; $display("FAIL tick_freeze: got floor %0d state %b pend %h expected 1 01 c0", current_floor, sim_state, pending);
    end
    repeat (3) step(1'b1, 8'h00);
    checks++;
    if (current_floor !== 3'd1) begin errors++; $display("FAIL tick_hold: got %0d expected 1", current_floor); end
    step(1'b1, 8'h00);
    checks++;
    if (current_floor !== 3'd2) begin errors++; $display("FAIL tick_resume: got %0d expected 2", current_floor); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'hF0);
    for (int c = 0; c < 40 && current_floor != 3'd2; c++) step(1'b1, 8'h00);
    repeat (2) step(1'b1, 8'h00);
    checks++;
    if ({current_floor, sim_state, pending} !== {3'd2, 2'b01, 8'hF0}) begin
      errors++; $display("FAIL arst_setup: got floor %0d state %b pend %h", current_floor, sim_state, pending);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {3'd0, 8'h01, 2'b00, 8'h00, 1'b1}) begin
      errors++; $display("FAIL arst_now: got %h expected %h", dut_vec, {3'd0, 8'h01, 2'b00, 8'h00, 1'b1});
    end
    model_reset();
  endtask

  task automatic test_all_calls();
    int         fl_q[$];
    logic [1:0] prev;
    bit         done, ok;
    done = 1'b0;
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    for (int c = 0; c < 400 && !done; c++) begin
      prev = sim_state;
      step(1'b1, 8'h00);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL all_model: got %h expected %h", dut_vec, exp_vec()); end
      if (sim_state == 2'b11 && prev != 2'b11) fl_q.push_back(int'(current_floor));
      if (sim_state == 2'b00 && fl_q.size() > 0) done = 1'b1;
    end
    ok = (fl_q.size() == 8);
    for (int i = 0; i < fl_q.size() && ok; i++) ok = (fl_q[i] == i);
    checks++;
    if (!ok) begin errors++; $display("FAIL all_order: got %0d stops, expected floors 0..7 ascending", fl_q.size()); end
    checks++;
    if ({current_floor, sim_state, pending} !== {3'd7, 2'b00, 8'h00}) begin
      errors++; $display("FAIL all_end: got floor %0d state %b pend %h expected 7 00 00", current_floor, sim_state, pending);
    end
  endtask

  task automatic test_random();
    logic [7:0] cr;
    bit         tk;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) do_reset();
      tk = ($urandom_range(0, 2) != 0);
      cr = 8'h00;
      if ($urandom_range(0, 9) == 0) cr = 8'h01 << $urandom_range(0, 7);
      if ($urandom_range(0, 29) == 0) cr = cr | (8'h01 << m_floor);
      if ($urandom_range(0, 99) == 0) cr = 8'($urandom_range(1, 255));
      step(tk, cr);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_model: cycle %0d got %h expected %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_order();
    test_call_at_floor();
    test_tick_gating();
    test_async_reset();
    test_all_calls();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Car-motion scheduler for the elevator controller. It latches floor call requests and runs a SCAN (elevator) policy: keep travelling while requests exist ahead, otherwise reverse or idle.
- It sequences travel and door timing from a tick enable.
- Its registered outputs drive the VGA display block directly: sim_state, the 8-bit destination, and current floor.

Parameters:
- NUM_FLOORS, 8, number of floors; destination width; floors 0..NUM_FLOORS-1.
- FLOOR_W, $clog2(NUM_FLOORS), floor index width.
- TRAVEL_TICKS, 4, tick pulses to move one floor (>=1).
- DOOR_TICKS, 3, tick pulses doors stay open (>=1).

Ports:
- clk  input  1  system clock (display/PLL clock domain).
- nrst  input  1  reset, asynchronous, active-low.
- tick  input  1  timebase enable, one-cycle pulse; only sampled-high cycles advance timers.
- call_req  input  NUM_FLOORS  call buttons, one bit per floor, level or pulse.
- current_floor  output  FLOOR_W  registered car position.
- destination  output  NUM_FLOORS  one-hot target floor.
- sim_state  output  2  00 idle, 01 moving up, 10 moving down, 11 doors open.
- pending  output  NUM_FLOORS  latched outstanding requests.
- dir_up  output  1  current/last travel direction, 1=up.

Behaviour:
- Reset (async, nrst=0):
  - current_floor=0, sim_state=00, pending=0, dir_up=1, timer=0.
  - destination=one-hot(0)=8'b0000_0001.
  - Applies mid-move or mid-door; no state is retained.
- Request latch:
  - pending[i] is set on the clk edge after call_req[i]=1, i.e. 1 cycle latency.
  - Bits are cleared only by door opening at that floor.
  - Same-cycle set and clear of the same bit: clear wins.
- Door-open re-press: call_req[current_floor]=1 while in DOOR_OPEN does not set pending and restarts the door timer to 0.
- Definitions: above = |pending bits > current_floor; below = |pending bits < current_floor.
- IDLE (00), evaluated each cycle on registered pending:
  - pending[current_floor] -> DOOR_OPEN, clear bit, timer=0.
  - else dir_up and above -> MOVE_UP.
  - else !dir_up and below -> MOVE_DOWN.
  - else above -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DOWN, dir_up=0.
  - else stay IDLE.
- MOVE_UP (01):
  - Timer increments on tick.
  - On tick with timer==TRAVEL_TICKS-1: current_floor+1, timer=0.
  - On that same edge: if pending[new floor] -> DOOR_OPEN and clear the bit; else remain MOVE_UP.
- MOVE_DOWN (10): mirror of MOVE_UP with current_floor-1.
- Floor bounds: current_floor never exceeds NUM_FLOORS-1 and never goes below 0. Entering MOVE_UP requires above, so these bounds are structural; add assertions.
- DOOR_OPEN (11): on tick with timer==DOOR_TICKS-1, next state is:
  - dir_up and above -> MOVE_UP.
  - else !dir_up and below -> MOVE_DOWN.
  - else above -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DOWN, dir_up=0.
  - else IDLE.
  - Timer resets to 0 on every state change.
- destination, registered:
  - Nearest pending floor strictly ahead in dir_up direction.
  - If none ahead, nearest pending in the opposite direction.
  - If pending is empty, current_floor.
  - Always exactly one bit set.
- tick low: timers hold; IDLE decisions and request latching still occur every clk.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Conditions: TRAVEL_TICKS=4, DOOR_TICKS=3, tick tied 1, edges counted from nrst release.
- Single call: call_req=8'h20 pulse at edge 0 -> pending=8'h20 at edge 1; sim_state=01 at edge 2; current_floor=5, sim_state=11, pending=0 at edge 22; sim_state=00 and destination=8'h20 at edge 25.
- SCAN order: car at floor 3 moving up with pending=8'h91 (floors 0,4,7) -> door stops in order 4, 7, then 0; destination=8'h10, then 8'h80, then 8'h01; dir_up drops to 0 only after the floor-7 door closes.
- Call at current floor: IDLE at 0, call_req=8'h01 -> sim_state=11 two edges later, pending stays 0. Re-press during door -> door period extends 3 ticks from the re-press.
- tick gating: tick pulsed every 4th cycle -> one-floor travel takes 16 clk; with tick=0 the state and timer freeze while pending still latches new calls.
- Async reset mid-travel: nrst low between floors 2 and 3 with pending=8'hF0 -> immediately current_floor=0, sim_state=00, pending=0, destination=8'h01, independent of clk.
- All calls: call_req=8'hFF from IDLE at floor 0 -> floor 0 door first, then stops at floors 1..7 ascending, then IDLE at floor 7 with pending=0.
